// File: rtl/wave_ram_bist_if.sv
// RAM-side port bundle between the wave RAM BIST engine and the simple-dual-port wave RAM.
// master = BIST engine side, slave = RAM side.
interface wave_ram_bist_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
);
    logic                  ram_wr_en;
    logic [ADDR_WIDTH-1:0] ram_wr_addr;
    logic [DATA_WIDTH-1:0] ram_wr_data;
    logic                  ram_rd_en;
    logic [ADDR_WIDTH-1:0] ram_rd_addr;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    modport master (
        output ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_en, ram_rd_addr,
        input  ram_rd_data
    );

    modport slave (
        input  ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_en, ram_rd_addr,
        output ram_rd_data
    );
endinterface

// File: rtl/wave_ram_bist.sv
// Wave RAM BIST engine: writes a pattern to every word, reads it back, counts mismatches.
// Optional first-failure capture ports are enabled by defining WAVE_BIST_FIRST_FAIL_EN.
module wave_ram_bist #(
    parameter int ADDR_WIDTH    = 10,
    parameter int DATA_WIDTH    = 8,
    parameter int RD_LATENCY    = 1,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     wr_clk,
    input  logic                     tb_wr_rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [1:0]               mode,
    wave_ram_bist_if.master          ram,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt
`ifdef WAVE_BIST_FIRST_FAIL_EN
    ,
    output logic                     fail_valid,
    output logic [ADDR_WIDTH-1:0]    fail_addr,
    output logic [DATA_WIDTH-1:0]    fail_exp,
    output logic [DATA_WIDTH-1:0]    fail_act
`endif
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WRITE = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]            state;
    logic [2:0]            state_nx;
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            mode_q;
    logic [RD_LATENCY-1:0] pipe_vld;
    logic [DATA_WIDTH-1:0] pipe_exp [RD_LATENCY];
    logic                  start_acc;
    logic                  mismatch;
    logic [DATA_WIDTH-1:0] pat_cur;

    // Pattern generator; mode 0 relies on all-ones minus a being the bitwise inverse of a.
    function automatic logic [DATA_WIDTH-1:0] pat(input logic [1:0] m, input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] a_t;
        logic [DATA_WIDTH-1:0] alt;
        a_t = DATA_WIDTH'(a);
        for (int i = 0; i < DATA_WIDTH; i++) begin
            alt[i] = (i % 2 == 0);
        end
        case (m)
            2'd0:    return ~a_t;
            2'd1:    return a_t;
            2'd2:    return a[0] ? ~alt : alt;
            default: return a[0] ? alt : ~alt;
        endcase
    endfunction

    assign start_acc = start && !abort && (state == ST_IDLE || state == ST_DONE);
    assign pat_cur   = pat(mode_q, addr);
    assign mismatch  = pipe_vld[RD_LATENCY-1] && (ram.ram_rd_data != pipe_exp[RD_LATENCY-1]);

    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: if (start) state_nx = ST_WRITE;
                ST_WRITE:         if (&addr) state_nx = ST_READ;
                ST_READ:          if (&addr) state_nx = ST_DRAIN;
                ST_DRAIN:         if (!(|pipe_vld)) state_nx = ST_DONE;
                default:          state_nx = ST_IDLE;
            endcase
        end
    end

    // The single address counter walks writes then reads and wraps between them.
    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            state    <= ST_IDLE;
            addr     <= '0;
            mode_q   <= '0;
            err_cnt  <= '0;
            pipe_vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_exp[i] <= '0;
            end
        end else begin
            state <= state_nx;
            if (abort) begin
                addr     <= '0;
                pipe_vld <= '0;
            end else begin
                if (start_acc) begin
                    addr    <= '0;
                    mode_q  <= mode;
                    err_cnt <= '0;
                end else if (state == ST_WRITE || state == ST_READ) begin
                    addr <= addr + 1'b1;
                end
                pipe_vld[0] <= (state == ST_READ);
                pipe_exp[0] <= pat_cur;
                for (int i = 1; i < RD_LATENCY; i++) begin
                    pipe_vld[i] <= pipe_vld[i-1];
                    pipe_exp[i] <= pipe_exp[i-1];
                end
                if (mismatch && !(&err_cnt)) begin
                    err_cnt <= err_cnt + 1'b1;
                end
            end
        end
    end

`ifdef WAVE_BIST_FIRST_FAIL_EN
    logic [ADDR_WIDTH-1:0] pipe_addr [RD_LATENCY];

    // Only the first mismatch of a run is kept; later ones leave the capture alone.
    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            fail_valid <= 1'b0;
            fail_addr  <= '0;
            fail_exp   <= '0;
            fail_act   <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_addr[i] <= '0;
            end
        end else begin
            pipe_addr[0] <= addr;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_addr[i] <= pipe_addr[i-1];
            end
            if (start_acc) begin
                fail_valid <= 1'b0;
                fail_addr  <= '0;
                fail_exp   <= '0;
                fail_act   <= '0;
            end else if (!abort && mismatch && !fail_valid) begin
                fail_valid <= 1'b1;
                fail_addr  <= pipe_addr[RD_LATENCY-1];
                fail_exp   <= pipe_exp[RD_LATENCY-1];
                fail_act   <= ram.ram_rd_data;
            end
        end
    end
`endif

    assign busy            = (state == ST_WRITE) || (state == ST_READ) || (state == ST_DRAIN);
    assign done            = (state == ST_DONE);
    assign pass            = done && (err_cnt == '0);
    assign ram.ram_wr_en   = (state == ST_WRITE);
    assign ram.ram_wr_addr = addr;
    assign ram.ram_wr_data = (state == ST_WRITE) ? pat_cur : '0;
    assign ram.ram_rd_en   = (state == ST_READ);
    assign ram.ram_rd_addr = addr;

endmodule

// File: tb/tb_wave_ram_bist.sv
// Scoreboard bench for wave_ram_bist: a behavioural RAM with injectable stuck bits,
// expected run results queued at start and checked by a monitor when done rises.
module tb_wave_ram_bist;

    localparam int          AW      = 10;
    localparam int          DW      = 8;
    localparam int          LAT     = 1;
    localparam int          EW      = 8;
    localparam int          DEPTH   = 1 << AW;
    localparam int unsigned RUN_CYC = 2 * DEPTH + LAT + 1;

    typedef struct {
        int unsigned    done_cyc;
        logic           pass;
        logic [EW-1:0]  err;
        logic           fvalid;
        logic [AW-1:0]  faddr;
        logic [DW-1:0]  fexp;
        logic [DW-1:0]  fact;
    } exp_t;

    logic          wr_clk = 1'b0;
    logic          tb_wr_rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          busy;
    logic          done;
    logic          pass;
    logic [EW-1:0] err_cnt;
`ifdef WAVE_BIST_FIRST_FAIL_EN
    logic          fail_valid;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_exp;
    logic [DW-1:0] fail_act;
`endif

    int          vectors = 0;
    int          fails = 0;
    int unsigned cyc = 0;
    int          fault_sel = 0;
    logic        prev_done = 1'b0;
    exp_t        exp_q[$];
    logic [DW-1:0] mem [DEPTH];

    wave_ram_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ram_if ();

    wave_ram_bist #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT), .ERR_CNT_WIDTH(EW)
    ) dut (
        .wr_clk    (wr_clk),
        .tb_wr_rst (tb_wr_rst),
        .start     (start),
        .abort     (abort),
        .mode      (mode),
        .ram       (ram_if),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_cnt   (err_cnt)
`ifdef WAVE_BIST_FIRST_FAIL_EN
        ,
        .fail_valid(fail_valid),
        .fail_addr (fail_addr),
        .fail_exp  (fail_exp),
        .fail_act  (fail_act)
`endif
    );

    always #5 wr_clk = ~wr_clk;

    always @(posedge wr_clk) cyc <= cyc + 1;

    // Fault 1: bit 3 of word 0x100 stuck-at-1. Fault 2: bit 0 of every word stuck-at-1.
    always @(posedge wr_clk) begin
        if (ram_if.ram_wr_en) mem[ram_if.ram_wr_addr] <= ram_if.ram_wr_data;
        if (ram_if.ram_rd_en)
            ram_if.ram_rd_data <= mem[ram_if.ram_rd_addr]
                | ((fault_sel == 1 && ram_if.ram_rd_addr == 10'h100) ? 8'h08 : 8'h00)
                | ((fault_sel == 2) ? 8'h01 : 8'h00);
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] m, input bit push, input logic [EW-1:0] e_err,
                                 input logic e_pass, input logic e_fv, input logic [AW-1:0] e_fa,
                                 input logic [DW-1:0] e_fe, input logic [DW-1:0] e_fact);
        exp_t e;
        @(negedge wr_clk);
        start = 1'b1;
        mode  = m;
        @(negedge wr_clk);
        start = 1'b0;
        if (push) begin
            e.done_cyc = cyc + RUN_CYC;
            e.pass     = e_pass;
            e.err      = e_err;
            e.fvalid   = e_fv;
            e.faddr    = e_fa;
            e.fexp     = e_fe;
            e.fact     = e_fact;
            exp_q.push_back(e);
        end
    endtask

    task automatic waitDone();
        int n = 0;
        while (exp_q.size() != 0 && n < 3 * DEPTH + 100) begin
            @(posedge wr_clk);
            n++;
        end
        checkOutput("done_timeout", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(negedge wr_clk);
    endtask

    task automatic waitWrAddr(input logic [AW-1:0] a);
        int n = 0;
        while (!(ram_if.ram_wr_en && ram_if.ram_wr_addr == a) && n < 5000) begin
            @(negedge wr_clk);
            n++;
        end
        checkOutput("wait_wr_addr_timeout", 64'(n >= 5000), 64'd0);
    endtask

    // Monitor: compares the oldest queued expectation whenever done rises.
    always @(negedge wr_clk) begin
        if (ram_if.ram_wr_en && ram_if.ram_rd_en) begin
            fails++;
            $display("[TB] FAIL rd_wr_overlap: got wr_en=1 rd_en=1, expected no overlap");
        end
        if (done && !prev_done) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_done", 64'd1, 64'd0);
            end else begin
                checkOutput("done_cycle", 64'(cyc), 64'(exp_q[0].done_cyc));
                checkOutput("pass", 64'(pass), 64'(exp_q[0].pass));
                checkOutput("err_cnt", 64'(err_cnt), 64'(exp_q[0].err));
`ifdef WAVE_BIST_FIRST_FAIL_EN
                checkOutput("fail_valid", 64'(fail_valid), 64'(exp_q[0].fvalid));
                if (exp_q[0].fvalid) begin
                    checkOutput("fail_addr", 64'(fail_addr), 64'(exp_q[0].faddr));
                    checkOutput("fail_exp", 64'(fail_exp), 64'(exp_q[0].fexp));
                    checkOutput("fail_act", 64'(fail_act), 64'(exp_q[0].fact));
                end
`endif
                exp_q.delete(0);
            end
        end
        prev_done <= done;
    end

    initial begin
        repeat (3) @(negedge wr_clk);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_err_cnt", 64'(err_cnt), 64'd0);
        checkOutput("rst_en", 64'({ram_if.ram_wr_en, ram_if.ram_rd_en}), 64'd0);
        tb_wr_rst = 1'b0;

        fault_sel = 0;
        applyStimulus(2'd0, 1'b1, 8'd0, 1'b1, 1'b0, 10'h0, 8'h00, 8'h00);
        waitDone();
        checkOutput("t1_mem0", 64'(mem[0]), 64'hFF);
        checkOutput("t1_mem1023", 64'(mem[1023]), 64'h00);
        checkOutput("t1_mem1a5", 64'(mem[10'h1A5]), 64'h5A);

        applyStimulus(2'd2, 1'b1, 8'd0, 1'b1, 1'b0, 10'h0, 8'h00, 8'h00);
        repeat (100) @(negedge wr_clk);
        applyStimulus(2'd1, 1'b0, 8'd0, 1'b0, 1'b0, 10'h0, 8'h00, 8'h00);
        waitDone();
        checkOutput("t2_mem0", 64'(mem[0]), 64'h55);
        checkOutput("t2_mem1", 64'(mem[1]), 64'hAA);
        checkOutput("t2_mem1023", 64'(mem[1023]), 64'hAA);

        fault_sel = 1;
        applyStimulus(2'd1, 1'b1, 8'd1, 1'b0, 1'b1, 10'h100, 8'h00, 8'h08);
        waitDone();

        fault_sel = 2;
        applyStimulus(2'd0, 1'b1, 8'hFF, 1'b0, 1'b1, 10'h001, 8'hFE, 8'hFF);
        waitDone();

        start = 1'b1;
        abort = 1'b1;
        mode  = 2'd1;
        @(negedge wr_clk);
        start = 1'b0;
        abort = 1'b0;
        checkOutput("abort_wins_done", 64'(done), 64'd0);
        checkOutput("abort_wins_busy", 64'(busy), 64'd0);
        checkOutput("abort_err_hold", 64'(err_cnt), 64'hFF);

        fault_sel = 0;
        applyStimulus(2'd0, 1'b0, 8'd0, 1'b0, 1'b0, 10'h0, 8'h00, 8'h00);
        waitWrAddr(10'h200);
        checkOutput("start_clears_err", 64'(err_cnt), 64'd0);
        abort = 1'b1;
        @(negedge wr_clk);
        abort = 1'b0;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_en", 64'({ram_if.ram_wr_en, ram_if.ram_rd_en}), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        applyStimulus(2'd3, 1'b1, 8'd0, 1'b1, 1'b0, 10'h0, 8'h00, 8'h00);
        waitDone();
        checkOutput("t5_mem0", 64'(mem[0]), 64'hAA);
        checkOutput("t5_mem1", 64'(mem[1]), 64'h55);

        applyStimulus(2'd1, 1'b0, 8'd0, 1'b0, 1'b0, 10'h0, 8'h00, 8'h00);
        waitWrAddr(10'h3FF);
        repeat (20) @(negedge wr_clk);
        #2 tb_wr_rst = 1'b1;
        #1;
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_en", 64'({ram_if.ram_wr_en, ram_if.ram_rd_en}), 64'd0);
        checkOutput("midrst_rd_addr", 64'(ram_if.ram_rd_addr), 64'd0);
        checkOutput("midrst_wr_data", 64'(ram_if.ram_wr_data), 64'd0);
        checkOutput("midrst_done_pass", 64'({done, pass}), 64'd0);
`ifdef WAVE_BIST_FIRST_FAIL_EN
        checkOutput("midrst_fail_valid", 64'(fail_valid), 64'd0);
`endif
        repeat (2) @(negedge wr_clk);
        tb_wr_rst = 1'b0;
        applyStimulus(2'd1, 1'b1, 8'd0, 1'b1, 1'b0, 10'h0, 8'h00, 8'h00);
        waitDone();
        checkOutput("t6_mem123", 64'(mem[10'h123]), 64'h23);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
